// File: rtl/ascon_mode_ctrl.sv
// ascon_mode_ctrl
//   Control FSM for the Ascon AEAD datapath. Sequences initialisation,
//   a run-time number of associated-data blocks, plaintext blocks and
//   finalisation. Owns the round counter and drives the round-constant
//   index, state-mux select and XOR/register enables for the datapath.
//   It also drives a valid/ready handshake toward the block-data source.
//
// Ports
//   clock_i, resetb_i   clock, asynchronous active-low reset
//   start_i             start one operation (sampled in IDLE only)
//   nb_ad_i, nb_txt_i   AD / plaintext block counts, captured at start
//   data_valid_i        source presents the next block
//   data_ready_o        FSM accepts a block (transfer = valid & ready)
//   round_o             round-constant index for this cycle
//   sel_init_o          state mux selects IV||K||N
//   en_reg_state_o      state register load enable
//   en_xor_data_o       XOR block into rate
//   en_xor_key_o        XOR key into capacity LSBs
//   en_xor_key_final_o  XOR key into capacity MSBs
//   en_xor_lsb_o        domain-separation XOR
//   en_cipher_o         latch ciphertext
//   cipher_valid_o      registered pulse, cycle after en_cipher_o
//   en_tag_o            latch tag
//   blk_idx_o           0-based block index within the current phase
//   busy_o              high outside IDLE
//   end_o               one-cycle pulse in DONE
module ascon_mode_ctrl #(
    parameter int unsigned ROUNDS_A = 12,
    parameter int unsigned ROUNDS_B = 6,
    parameter int unsigned BLK_W    = 8,
    parameter int unsigned RND_W    = 4
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic [BLK_W-1:0] nb_ad_i,
    input  logic [BLK_W-1:0] nb_txt_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic [RND_W-1:0] round_o,
    output logic             sel_init_o,
    output logic             en_reg_state_o,
    output logic             en_xor_data_o,
    output logic             en_xor_key_o,
    output logic             en_xor_key_final_o,
    output logic             en_xor_lsb_o,
    output logic             en_cipher_o,
    output logic             cipher_valid_o,
    output logic             en_tag_o,
    output logic [BLK_W-1:0] blk_idx_o,
    output logic             busy_o,
    output logic             end_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_WAIT_AD, S_AD_PERM, S_DSEP,
        S_WAIT_TXT, S_TXT_PERM, S_WAIT_FIN, S_FIN_PERM, S_DONE
    } state_t;

    localparam logic [RND_W-1:0] LP_LAST_A = RND_W'(ROUNDS_A - 1);
    localparam logic [RND_W-1:0] LP_LAST_B = RND_W'(ROUNDS_B - 1);
    localparam logic [RND_W-1:0] LP_OFS_B  = RND_W'(ROUNDS_A - ROUNDS_B);

    state_t           r_state, w_state_nxt;
    logic [RND_W-1:0] r_rnd, w_rnd_nxt;
    logic [BLK_W-1:0] r_blk, w_blk_nxt;
    logic [BLK_W-1:0] r_nb_ad, r_nb_txt;
    logic             r_cipher_valid;

    logic [BLK_W-1:0] w_blk_inc;
    logic             w_ad_more;
    logic             w_txt_more;
    logic             w_txt_multi;

    assign w_blk_inc   = r_blk + 1'b1;
    assign w_ad_more   = (w_blk_inc < r_nb_ad);
    // TXT_PERM only covers blocks 0..nb_txt-2; the last one goes to FIN_PERM.
    assign w_txt_more  = (w_blk_inc < (r_nb_txt - 1'b1));
    assign w_txt_multi = (r_nb_txt > BLK_W'(1));

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state        <= S_IDLE;
            r_rnd          <= '0;
            r_blk          <= '0;
            r_cipher_valid <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_rnd          <= w_rnd_nxt;
            r_blk          <= w_blk_nxt;
            r_cipher_valid <= en_cipher_o;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_nb_ad  <= '0;
            r_nb_txt <= '0;
        end else if (r_state == S_IDLE && start_i) begin
            r_nb_ad  <= nb_ad_i;
            r_nb_txt <= (nb_txt_i == '0) ? BLK_W'(1) : nb_txt_i;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_rnd_nxt          = r_rnd;
        w_blk_nxt          = r_blk;
        data_ready_o       = 1'b0;
        round_o            = '0;
        sel_init_o         = 1'b0;
        en_reg_state_o     = 1'b0;
        en_xor_data_o      = 1'b0;
        en_xor_key_o       = 1'b0;
        en_xor_key_final_o = 1'b0;
        en_xor_lsb_o       = 1'b0;
        en_cipher_o        = 1'b0;
        en_tag_o           = 1'b0;
        end_o              = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_INIT;
                    w_rnd_nxt   = '0;
                    w_blk_nxt   = '0;
                end
            end
            S_INIT: begin
                en_reg_state_o = 1'b1;
                round_o        = r_rnd;
                sel_init_o     = (r_rnd == '0);
                if (r_rnd == LP_LAST_A) begin
                    en_xor_key_o = 1'b1;
                    w_rnd_nxt    = '0;
                    w_state_nxt  = (r_nb_ad != '0) ? S_WAIT_AD : S_DSEP;
                end else begin
                    w_rnd_nxt = r_rnd + 1'b1;
                end
            end
            S_WAIT_AD: begin
                data_ready_o = 1'b1;
                if (data_valid_i) w_state_nxt = S_AD_PERM;
            end
            S_AD_PERM: begin
                en_reg_state_o = 1'b1;
                round_o        = LP_OFS_B + r_rnd;
                en_xor_data_o  = (r_rnd == '0);
                if (r_rnd == LP_LAST_B) begin
                    w_rnd_nxt = '0;
                    if (w_ad_more) begin
                        w_blk_nxt   = w_blk_inc;
                        w_state_nxt = S_WAIT_AD;
                    end else begin
                        en_xor_lsb_o = 1'b1;
                        w_blk_nxt    = '0;
                        w_state_nxt  = w_txt_multi ? S_WAIT_TXT : S_WAIT_FIN;
                    end
                end else begin
                    w_rnd_nxt = r_rnd + 1'b1;
                end
            end
            S_DSEP: begin
                en_reg_state_o = 1'b1;
                en_xor_lsb_o   = 1'b1;
                w_state_nxt    = w_txt_multi ? S_WAIT_TXT : S_WAIT_FIN;
            end
            S_WAIT_TXT: begin
                data_ready_o = 1'b1;
                if (data_valid_i) w_state_nxt = S_TXT_PERM;
            end
            S_TXT_PERM: begin
                en_reg_state_o = 1'b1;
                round_o        = LP_OFS_B + r_rnd;
                en_xor_data_o  = (r_rnd == '0);
                en_cipher_o    = (r_rnd == '0);
                if (r_rnd == LP_LAST_B) begin
                    w_rnd_nxt   = '0;
                    w_blk_nxt   = w_blk_inc;
                    w_state_nxt = w_txt_more ? S_WAIT_TXT : S_WAIT_FIN;
                end else begin
                    w_rnd_nxt = r_rnd + 1'b1;
                end
            end
            S_WAIT_FIN: begin
                data_ready_o = 1'b1;
                if (data_valid_i) w_state_nxt = S_FIN_PERM;
            end
            S_FIN_PERM: begin
                en_reg_state_o     = 1'b1;
                round_o            = r_rnd;
                en_xor_data_o      = (r_rnd == '0);
                en_cipher_o        = (r_rnd == '0);
                en_xor_key_final_o = (r_rnd == '0);
                if (r_rnd == LP_LAST_A) begin
                    en_xor_key_o = 1'b1;
                    en_tag_o     = 1'b1;
                    w_rnd_nxt    = '0;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_rnd_nxt = r_rnd + 1'b1;
                end
            end
            S_DONE: begin
                end_o       = 1'b1;
                w_blk_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_rnd_nxt   = '0;
                w_blk_nxt   = '0;
            end
        endcase
    end

    assign cipher_valid_o = r_cipher_valid;
    assign blk_idx_o      = r_blk;
    assign busy_o         = (r_state != S_IDLE);

endmodule
